// File: rtl/dll_pkg.sv
// Data link layer shared definitions: LCRC-32 constants and the
// byte-wide reflected CRC update used by both RX check and TX generate.
package dll_pkg;

  localparam int          SEQ_W          = 12;
  localparam logic [31:0] LCRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] LCRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] LCRC_XOROUT    = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ LCRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dll_seq_tracker.sv
// Receive sequence tracking: expected-sequence register, duplicate
// versus ahead classification and one-cycle ACK/NAK/DUP verdicts.
module dll_seq_tracker #(
  parameter int SEQ_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_judge,
  input  logic             i_crc_ok,
  input  logic             i_bad,
  input  logic [SEQ_W-1:0] i_seq,
  output logic             o_in_seq,
  output logic             o_ack,
  output logic             o_nak,
  output logic             o_dup,
  output logic [SEQ_W-1:0] o_pkt_seq,
  output logic [SEQ_W-1:0] o_next_seq
);

  localparam logic [SEQ_W-1:0] L_HALF =
    {1'b1, {(SEQ_W-1){1'b0}}};

  logic [SEQ_W-1:0] w_diff;
  logic             w_dup;

  // Distance behind the expected number; up to half the space is a replay.
  assign w_diff   = o_next_seq - i_seq;
  assign o_in_seq = (w_diff == '0);
  assign w_dup    = !o_in_seq && (w_diff <= L_HALF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_ack      <= 1'b0;
      o_nak      <= 1'b0;
      o_dup      <= 1'b0;
      o_pkt_seq  <= '0;
      o_next_seq <= '0;
    end else begin
      o_ack <= 1'b0;
      o_nak <= 1'b0;
      o_dup <= 1'b0;
      if (i_judge) begin
        o_pkt_seq <= i_seq;
        if (!i_crc_ok) begin
          o_nak <= 1'b1;
        end else if (o_in_seq) begin
          o_ack      <= 1'b1;
          o_next_seq <= o_next_seq + 1'b1;
        end else if (w_dup) begin
          o_dup <= 1'b1;
        end else begin
          o_nak <= 1'b1;
        end
      end else if (i_bad) begin
        o_nak <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dll_rx_lcrc_check.sv
// RX data link stage: strips sequence and LCRC bytes, checks the
// LCRC on the fly and forwards payload with a per-packet verdict.
module dll_rx_lcrc_check #(
  parameter int SEQ_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_drop,
  output logic [7:0]       out_data,
  output logic             ack_pulse,
  output logic             nak_pulse,
  output logic             dup_pulse,
  output logic [SEQ_W-1:0] pkt_seq,
  output logic [SEQ_W-1:0] next_rcv_seq,
  output logic [CNT_W-1:0] crc_err_cnt
);

  import dll_pkg::crc32_byte;
  import dll_pkg::LCRC_INIT;
  import dll_pkg::LCRC_XOROUT;

  logic             r_active;
  logic [2:0]       r_cnt;
  logic [3:0][7:0]  r_dl;
  logic [31:0]      r_crc;
  logic [SEQ_W-1:0] r_seq;

  logic        w_new;
  logic        w_acc;
  logic        w_abort;
  logic        w_eop;
  logic        w_fold;
  logic        w_fwd;
  logic        w_judge;
  logic        w_bad;
  logic        w_crc_ok;
  logic        w_in_seq;
  logic [31:0] w_crc_nxt;
  logic [31:0] w_rx_crc;

  // r_cnt saturates at 7: only thresholds 4, 6 and 7 matter.
  assign w_new     = in_valid && in_sop;
  assign w_acc     = in_valid && (in_sop || r_active);
  assign w_abort   = w_new && r_active;
  assign w_eop     = w_acc && in_eop;
  assign w_fold    = w_acc && !w_new && (r_cnt >= 3'd4);
  assign w_fwd     = w_acc && !w_new && (r_cnt >= 3'd6);
  assign w_judge   = w_eop && !w_new && (r_cnt >= 3'd6);
  assign w_bad     = w_abort || (w_eop && !w_judge);
  assign w_crc_nxt = crc32_byte(r_crc, r_dl[3]);
  assign w_rx_crc  = {in_data, r_dl[0], r_dl[1], r_dl[2]};
  assign w_crc_ok  = ((w_crc_nxt ^ LCRC_XOROUT) == w_rx_crc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active    <= 1'b0;
      r_cnt       <= '0;
      r_dl        <= '0;
      r_crc       <= LCRC_INIT;
      r_seq       <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_drop    <= 1'b0;
      out_data    <= '0;
      crc_err_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_drop  <= 1'b0;
      out_data  <= '0;
      if (w_abort && (r_cnt == 3'd7)) begin
        out_valid <= 1'b1;
        out_eop   <= 1'b1;
        out_drop  <= 1'b1;
      end
      if (w_fwd) begin
        out_valid <= 1'b1;
        out_sop   <= (r_cnt == 3'd6);
        out_data  <= r_dl[3];
        out_eop   <= in_eop;
        out_drop  <= in_eop && !(w_crc_ok && w_in_seq);
      end
      if (w_judge && !w_crc_ok && (crc_err_cnt != '1)) begin
        crc_err_cnt <= crc_err_cnt + 1'b1;
      end
      if (w_new) begin
        r_active <= !in_eop;
        r_cnt    <= 3'd1;
        r_crc    <= LCRC_INIT;
        r_dl     <= {24'd0, in_data};
        r_seq[SEQ_W-1:8] <= in_data[SEQ_W-9:0];
      end else if (w_acc) begin
        r_active <= !in_eop;
        if (r_cnt != 3'd7) begin
          r_cnt <= r_cnt + 3'd1;
        end
        r_dl <= {r_dl[2:0], in_data};
        if (w_fold) begin
          r_crc <= w_crc_nxt;
        end
        if (r_cnt == 3'd1) begin
          r_seq[7:0] <= in_data;
        end
      end
    end
  end

  dll_seq_tracker #(
    .SEQ_W (SEQ_W)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .i_judge    (w_judge),
    .i_crc_ok   (w_crc_ok),
    .i_bad      (w_bad),
    .i_seq      (r_seq),
    .o_in_seq   (w_in_seq),
    .o_ack      (ack_pulse),
    .o_nak      (nak_pulse),
    .o_dup      (dup_pulse),
    .o_pkt_seq  (pkt_seq),
    .o_next_seq (next_rcv_seq)
  );

endmodule

// File: tb/tb_dll_rx_lcrc_check.sv
// Bench for dll_rx_lcrc_check: packet table plus scoreboard of
// expected output cycles, with reset and gap corner sequences.
module tb_dll_rx_lcrc_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sop, in_eop;
  logic [7:0]  in_data;
  logic        out_valid, out_sop, out_eop, out_drop;
  logic [7:0]  out_data;
  logic        ack_pulse, nak_pulse, dup_pulse;
  logic [11:0] pkt_seq, next_rcv_seq;
  logic [15:0] crc_err_cnt;

  always #5 clk = ~clk;

  dll_rx_lcrc_check #(.SEQ_W(12), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_drop     (out_drop),
    .out_data     (out_data),
    .ack_pulse    (ack_pulse),
    .nak_pulse    (nak_pulse),
    .dup_pulse    (dup_pulse),
    .pkt_seq      (pkt_seq),
    .next_rcv_seq (next_rcv_seq),
    .crc_err_cnt  (crc_err_cnt)
  );

  typedef struct packed {
    logic        v, s, e, d;
    logic [7:0]  data;
    logic [2:0]  pulse;
    logic        chk_st, chk_seq;
    logic [11:0] seq, nxt;
    logic [15:0] err;
  } ev_t;

  typedef struct packed {
    logic [127:0] b;
    int           len;
    logic         gap, abort;
    logic [2:0]   pulse;
    logic         drop, chk_seq;
    logic [11:0]  seq, nxt;
    logic [15:0]  err;
  } vec_t;

  localparam logic [2:0] P_ACK = 3'b100;
  localparam logic [2:0] P_NAK = 3'b010;
  localparam logic [2:0] P_DUP = 3'b001;

  ev_t  q[$];
  vec_t tbl [9];
  vec_t g;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ev_idx = 0;

  function automatic logic [7:0] bt(input vec_t v, input int i);
    return v.b[127 - 8*i -: 8];
  endfunction

  task automatic drive(input logic s, input logic e, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [63:0] got;
    got = {out_valid, out_sop, out_eop, out_drop, out_data,
           ack_pulse, nak_pulse, dup_pulse,
           pkt_seq, next_rcv_seq, crc_err_cnt};
    n_chk++;
    if (got == '0) n_pass++;
    else $display("FAIL %s: outputs=%h required all zero", name, got);
  endtask

  task automatic apply(input vec_t v);
    ev_t x;
    int  n;
    n = v.len;
    if (n >= 7) begin
      for (int i = 2; i <= n - 5; i++) begin
        x      = '0;
        x.v    = 1'b1;
        x.s    = (i == 2);
        x.data = bt(v, i);
        if (i == n - 5 && !v.abort) begin
          x.e       = 1'b1;
          x.d       = v.drop;
          x.pulse   = v.pulse;
          x.chk_st  = 1'b1;
          x.chk_seq = v.chk_seq;
          x.seq     = v.seq;
          x.nxt     = v.nxt;
          x.err     = v.err;
        end
        q.push_back(x);
      end
    end
    if (v.abort || n < 7) begin
      x        = '0;
      x.pulse  = P_NAK;
      x.chk_st = 1'b1;
      x.nxt    = v.nxt;
      x.err    = v.err;
      if (v.abort && n >= 7) begin
        x.v = 1'b1;
        x.e = 1'b1;
        x.d = 1'b1;
      end
      q.push_back(x);
    end
    for (int i = 0; i < n; i++) begin
      drive(i == 0, !v.abort && i == n - 1, bt(v, i));
      if (v.gap) idle();
    end
    if (!v.gap) idle();
  endtask

  always @(negedge clk) begin : mon
    ev_t  x;
    logic ok;
    if (reset && (out_valid || ack_pulse || nak_pulse || dup_pulse)) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_out: v=%b e=%b data=%h p=%b%b%b, required no output",
                 out_valid, out_eop, out_data, ack_pulse, nak_pulse, dup_pulse);
      end else begin
        x  = q.pop_front();
        ok = (out_valid == x.v) && (out_sop == x.s) &&
             (out_eop == x.e) && (out_drop == x.d) &&
             (!x.v || out_data == x.data) &&
             ({ack_pulse, nak_pulse, dup_pulse} == x.pulse) &&
             (!x.chk_st || (next_rcv_seq == x.nxt && crc_err_cnt == x.err)) &&
             (!x.chk_seq || pkt_seq == x.seq);
        if (ok) n_pass++;
        else $display({"FAIL ev%0d: got v%b s%b e%b d%b data=%h p=%b%b%b seq=%h nxt=%h err=%0d",
                       " required v%b s%b e%b d%b data=%h p=%b seq=%h nxt=%h err=%0d"},
                      ev_idx, out_valid, out_sop, out_eop, out_drop, out_data,
                      ack_pulse, nak_pulse, dup_pulse, pkt_seq, next_rcv_seq, crc_err_cnt,
                      x.v, x.s, x.e, x.d, x.data, x.pulse, x.seq, x.nxt, x.err);
      end
      ev_idx++;
    end
  end

  initial begin
    tbl[0] = '{b:{64'h000000001CDF4421, 64'h0}, len:8, gap:0, abort:0,
               pulse:P_ACK, drop:0, chk_seq:1, seq:12'h000, nxt:12'd1, err:16'd0};
    tbl[1] = '{b:{64'h000000001CDF4421, 64'h0}, len:8, gap:0, abort:0,
               pulse:P_DUP, drop:1, chk_seq:1, seq:12'h000, nxt:12'd1, err:16'd0};
    tbl[2] = '{b:{64'h000000001CDF4420, 64'h0}, len:8, gap:0, abort:0,
               pulse:P_NAK, drop:1, chk_seq:1, seq:12'h000, nxt:12'd1, err:16'd1};
    tbl[3] = '{b:{104'h3132333435363738392639F4CB, 24'h0}, len:13, gap:0, abort:0,
               pulse:P_NAK, drop:1, chk_seq:1, seq:12'h132, nxt:12'd1, err:16'd1};
    tbl[4] = '{b:{40'h000000001C, 88'h0}, len:5, gap:0, abort:0,
               pulse:P_NAK, drop:0, chk_seq:0, seq:12'h000, nxt:12'd1, err:16'd1};
    tbl[5] = '{b:{8'hAA, 120'h0}, len:1, gap:0, abort:0,
               pulse:P_NAK, drop:0, chk_seq:0, seq:12'h000, nxt:12'd1, err:16'd1};
    tbl[6] = '{b:{24'h000000, 104'h0}, len:3, gap:0, abort:1,
               pulse:P_NAK, drop:0, chk_seq:0, seq:12'h000, nxt:12'd1, err:16'd1};
    tbl[7] = '{b:{72'h313233343536373839, 56'h0}, len:9, gap:0, abort:1,
               pulse:P_NAK, drop:1, chk_seq:0, seq:12'h000, nxt:12'd1, err:16'd1};
    tbl[8] = '{b:{64'h000000001CDF4421, 64'h0}, len:8, gap:0, abort:0,
               pulse:P_DUP, drop:1, chk_seq:1, seq:12'h000, nxt:12'd1, err:16'd1};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    idle();

    for (int k = 0; k < 9; k++) apply(tbl[k]);

    for (int i = 0; i < 5; i++) drive(i == 0, 1'b0, bt(tbl[0], i));
    idle();
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk) reset = 1'b1;
    idle();

    g     = tbl[0];
    g.gap = 1'b1;
    apply(g);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dll_rx_lcrc_check.md
Name: dll_rx_lcrc_check

Overview:
- Receive-side data link layer stage that consumes byte-serial packets carrying a 12-bit sequence header and a trailing 32-bit LCRC.
- The LCRC is generated by the transmit-side LCRC-32 block, polynomial 0x04C11DB7.
- Recomputes the LCRC on the fly and strips the sequence and LCRC bytes.
- Forwards the payload downstream and issues ACK/NAK/duplicate verdicts with sequence tracking toward the replay/ACK-NAK scheduler.

Parameters:
- SEQ_W, 12, sequence number width. Fixed by protocol; the parameter exists for documentation only.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  byte qualifier
- in_sop  input  1  first byte of packet (valid only with in_valid)
- in_eop  input  1  last byte of packet (valid only with in_valid)
- in_data  input  8  packet byte
- out_valid  output  1  payload byte / marker qualifier
- out_sop  output  1  first payload byte
- out_eop  output  1  packet end marker (verdict cycle)
- out_drop  output  1  with out_eop: consumer discards the packet
- out_data  output  8  payload byte
- ack_pulse  output  1  good, in-sequence packet
- nak_pulse  output  1  CRC error, sequence error, malformed, or aborted packet
- dup_pulse  output  1  good CRC, duplicate sequence, packet dropped
- pkt_seq  output  12  sequence field of the packet just judged
- next_rcv_seq  output  12  expected sequence number
- crc_err_cnt  output  CNT_W  saturating count of CRC failures

Behaviour:
- Reset (async, active-low) values:
  - All outputs 0.
  - next_rcv_seq = 0.
  - CRC register = 0xFFFFFFFF.
  - Byte index = 0; packet inactive.
- Packet format: byte0[3:0] = seq[11:8] (byte0[7:4] reserved, ignored); byte1 = seq[7:0]; bytes 2..n-5 are payload; bytes n-4..n-1 are the LCRC, least-significant byte first.
- CRC algorithm: standard reflected CRC-32.
  - Initial register 0xFFFFFFFF.
  - Each byte is shifted LSB first through the reflected form 0xEDB88320.
  - Final value = register XOR 0xFFFFFFFF.
  - Computed over bytes 0..n-5, including the sequence bytes.
  - Single-byte-per-cycle combinational update (one function).
- 4-byte delay line:
  - Each accepted byte enters the delay line.
  - When the line is full, the oldest byte is folded into the CRC.
  - Bytes with index ≥2 are forwarded as payload.
  - The last 4 bytes are never folded and are compared against the computed CRC at in_eop.
- Output register stage:
  - Payload byte i is driven on out_* one cycle after input byte i+4 is accepted.
  - The out_eop/verdict cycle is one cycle after in_eop is accepted.
  - The final payload byte is carried in that same cycle with out_eop=1.
- Gaps: in_valid may deassert at any time mid-packet; state holds.
- Verdict, one cycle after in_eop; exactly one of ack/nak/dup pulses for one cycle:
  - n < 7: malformed. nak_pulse; no out_* activity (no payload byte was ever emitted).
  - CRC mismatch: nak_pulse, out_drop=1, crc_err_cnt+1 (saturating).
  - CRC ok, seq == next_rcv_seq: ack_pulse, out_drop=0, next_rcv_seq+1 mod 4096.
  - CRC ok, (next_rcv_seq − seq) mod 4096 in 1..2048: dup_pulse, out_drop=1.
  - CRC ok, otherwise: nak_pulse, out_drop=1.
  - pkt_seq is updated in the verdict cycle and holds until the next verdict.
- in_sop while a packet is active (abort):
  - If ≥7 bytes were accepted: emit a marker cycle with out_valid=1, out_eop=1, out_drop=1, out_data=0, plus nak_pulse.
  - If fewer than 7: nak_pulse only.
  - The new sop byte starts a fresh packet in the same cycle (CRC reinitialised, delay line cleared).
- Bytes with in_valid=1 while no packet is active and in_sop=0 are ignored.
- in_sop and in_eop together form a 1-byte packet, treated as malformed.
- The block has no backpressure; the consumer always accepts.

Decomposition:
- Shared package dll_pkg holds:
  - LCRC_POLY_REFL = 32'hEDB88320
  - LCRC_INIT = 32'hFFFFFFFF
  - LCRC_XOROUT = 32'hFFFFFFFF
  - SEQ_W = 12
  - the crc32_byte update function, shared with the transmit generator
- Optional sub-module dll_seq_tracker: next_rcv_seq register, duplicate/ahead classification, and verdict pulse generation.

Test Plan:
- Good packet: bytes 00 00 00 00 1C DF 44 21, seq expected 0 -> payload 00 00 with out_sop on first; out_eop, out_drop=0, ack_pulse, pkt_seq=0, next_rcv_seq=1.
- Corrupt LCRC: same packet with last byte 20 -> out_drop=1, nak_pulse, crc_err_cnt=1, next_rcv_seq unchanged.
- Sequence ahead: bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, expected 0 -> CRC ok, pkt_seq=0x132, nak_pulse, out_drop=1.
- Duplicate: send the good packet twice -> second gives dup_pulse, out_drop=1, next_rcv_seq stays 1.
- Gapped input plus abort: the good packet with in_valid low on alternating cycles -> identical result. A packet aborted by in_sop after 9 bytes -> drop marker, nak_pulse, and the following packet is judged correctly.
- Reset mid-packet: reset asserted after 5 bytes -> all outputs 0 immediately; the next full good packet gives ack_pulse with pkt_seq=0.
